// File: rtl/crypto_wallet_gpio_rmw_arbiter.sv
// Two-requester Avalon-MM master for a bidirectional GPIO PIO. It keeps shadow copies of
// data_out and data_dir, so each masked bit operation becomes a full-word PIO write.
module crypto_wallet_gpio_rmw_arbiter #(
  parameter int WIDTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_mask,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_done,
  output logic [WIDTH-1:0] req0_rdata,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_mask,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_done,
  output logic [WIDTH-1:0] req1_rdata,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [WIDTH-1:0] pio_writedata,
  input  logic [WIDTH-1:0] pio_readdata,
  output logic [WIDTH-1:0] out_shadow,
  output logic [WIDTH-1:0] dir_shadow
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RWAIT, S_RESP} state_e;

  localparam logic [1:0] OP_RDPIN = 2'b00;
  localparam logic [1:0] OP_WROUT = 2'b01;
  localparam logic [1:0] OP_WRDIR = 2'b10;
  localparam logic [1:0] OP_RDDIR = 2'b11;

  state_e             state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               last_grant_q, last_grant_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   out_shadow_q, out_shadow_d;
  logic [WIDTH-1:0]   dir_shadow_q, dir_shadow_d;
  logic [WIDTH-1:0]   rdata0_q, rdata0_d;
  logic [WIDTH-1:0]   rdata1_q, rdata1_d;
  logic               pick;
  logic [WIDTH-1:0]   write_val;

  // NOTE: every combinational output and next-state gets a default first, so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    last_grant_d   = last_grant_q;
    op_d           = op_q;
    mask_d         = mask_q;
    data_d         = data_q;
    out_shadow_d   = out_shadow_q;
    dir_shadow_d   = dir_shadow_q;
    rdata0_d       = rdata0_q;
    rdata1_d       = rdata1_q;
    pio_address    = 2'd0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    req0_done      = 1'b0;
    req1_done      = 1'b0;

    // Round-robin favours whoever was not served last; a lone requester always wins.
    if (req0_valid && req1_valid) pick = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    else                          pick = req1_valid;

    write_val = (((op_q == OP_WRDIR) ? dir_shadow_q : out_shadow_q) & ~mask_q)
              | (data_q & mask_q);

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_d   = pick;
          op_d    = pick ? req1_op   : req0_op;
          mask_d  = pick ? req1_mask : req0_mask;
          data_d  = pick ? req1_data : req0_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_WROUT: begin
            pio_chipselect = 1'b1;
            pio_write_n    = 1'b0;
            pio_writedata  = write_val;
            out_shadow_d   = write_val;
            state_d        = S_RESP;
          end
          OP_WRDIR: begin
            pio_address    = 2'd1;
            pio_chipselect = 1'b1;
            pio_write_n    = 1'b0;
            pio_writedata  = write_val;
            dir_shadow_d   = write_val;
            state_d        = S_RESP;
          end
          OP_RDPIN: begin
            pio_chipselect = 1'b1;
            state_d        = S_RWAIT;
          end
          default: begin
            if (gnt_q) rdata1_d = dir_shadow_q;
            else       rdata0_d = dir_shadow_q;
            state_d = S_RESP;
          end
        endcase
      end
      S_RWAIT: begin
        // PIO readdata is registered, so the value for the EXEC address arrives now.
        if (gnt_q) rdata1_d = pio_readdata;
        else       rdata0_d = pio_readdata;
        state_d = S_RESP;
      end
      S_RESP: begin
        req0_done    = ~gnt_q;
        req1_done    = gnt_q;
        last_grant_d = gnt_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= OP_RDPIN;
      mask_q       <= '0;
      data_q       <= '0;
      out_shadow_q <= '0;
      dir_shadow_q <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      mask_q       <= mask_d;
      data_q       <= data_d;
      out_shadow_q <= out_shadow_d;
      dir_shadow_q <= dir_shadow_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign out_shadow = out_shadow_q;
  assign dir_shadow = dir_shadow_q;

endmodule

// File: tb/tb_crypto_wallet_gpio_rmw_arbiter.sv
// Scoreboard bench for the GPIO RMW arbiter: expected bus accesses and responses are queued
// when requests are driven and compared when the DUT produces them.
module tb_crypto_wallet_gpio_rmw_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0]   req0_op = 2'b00, req1_op = 2'b00;
  logic [W-1:0] req0_mask = '0, req1_mask = '0, req0_data = '0, req1_data = '0;
  logic         req0_done, req1_done;
  logic [W-1:0] req0_rdata, req1_rdata;
  logic [1:0]   pio_address;
  logic         pio_chipselect, pio_write_n;
  logic [W-1:0] pio_writedata, out_shadow, dir_shadow;
  logic [W-1:0] pio_rd = '0;
  logic [W-1:0] pins = '0;

  logic         f_done0, f_done1, f_cs, f_wn;
  logic [W-1:0] f_rdata0, f_rdata1, f_wdata, f_out, f_dir;
  logic [1:0]   f_addr;

  always #5 clk = ~clk;

  crypto_wallet_gpio_rmw_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_mask(req0_mask), .req0_data(req0_data),
    .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_mask(req1_mask), .req1_data(req1_data),
    .req1_done(req1_done), .req1_rdata(req1_rdata),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata), .pio_readdata(pio_rd),
    .out_shadow(out_shadow), .dir_shadow(dir_shadow)
  );

  crypto_wallet_gpio_rmw_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b1)) dut_fix (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_mask(req0_mask), .req0_data(req0_data),
    .req0_done(f_done0), .req0_rdata(f_rdata0),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_mask(req1_mask), .req1_data(req1_data),
    .req1_done(f_done1), .req1_rdata(f_rdata1),
    .pio_address(f_addr), .pio_chipselect(f_cs), .pio_write_n(f_wn),
    .pio_writedata(f_wdata), .pio_readdata(pio_rd),
    .out_shadow(f_out), .dir_shadow(f_dir)
  );

  // PIO model: registered readdata, pins visible only for a real read of address 0.
  always @(posedge clk)
    pio_rd <= (pio_chipselect && pio_write_n && pio_address == 2'd0) ? pins : '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct { logic id; logic [W-1:0] rdata; } resp_t;
  typedef struct { logic [1:0] addr; logic wr; logic [W-1:0] data; } bus_t;
  resp_t resp_q[$];
  bus_t  bus_q[$];

  logic [W-1:0] m_out = '0, m_dir = '0;
  logic [W-1:0] m_rd [2] = '{default: '0};
  logic         m_last = 1'b1;
  int           cs_cnt = 0;
  int           f0_cnt = 0, f1_cnt = 0;

  // Monitor: compares every bus access and every done pulse against the queues.
  always @(negedge clk) begin
    if (pio_chipselect) begin
      cs_cnt++;
      if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
      else begin
        bus_t b;
        b = bus_q.pop_front();
        check("bus_addr", {30'd0, pio_address}, {30'd0, b.addr});
        check("bus_write_n", {31'd0, pio_write_n}, {31'd0, ~b.wr});
        if (b.wr) check("bus_wdata", pio_writedata, b.data);
      end
    end
    if (req0_done && req1_done) check("done_both", 1, 0);
    else if (req0_done || req1_done) begin
      if (resp_q.size() == 0) check("resp_unexpected", 1, 0);
      else begin
        resp_t r;
        r = resp_q.pop_front();
        check("resp_id", {31'd0, req1_done}, {31'd0, r.id});
        check("resp_rdata", req1_done ? req1_rdata : req0_rdata, r.rdata);
      end
    end
    if (f_done0) f0_cnt++;
    if (f_done1) f1_cnt++;
  end

  task automatic drive(input int r, input logic v, input logic [1:0] op,
                       input logic [W-1:0] mask, input logic [W-1:0] data);
    if (r == 0) begin req0_valid = v; req0_op = op; req0_mask = mask; req0_data = data; end
    else        begin req1_valid = v; req1_op = op; req1_mask = mask; req1_data = data; end
  endtask

  task automatic do_req(input int r, input logic [1:0] op, input logic [W-1:0] mask,
                        input logic [W-1:0] data, input int exp_lat, input int exp_cs);
    logic [W-1:0] v;
    int lat, cs0;
    bit seen;
    case (op)
      2'b01: begin v = (m_out & ~mask) | (data & mask); m_out = v; bus_q.push_back('{2'd0, 1'b1, v}); end
      2'b10: begin v = (m_dir & ~mask) | (data & mask); m_dir = v; bus_q.push_back('{2'd1, 1'b1, v}); end
      2'b00: begin m_rd[r] = pins; bus_q.push_back('{2'd0, 1'b0, '0}); end
      default: m_rd[r] = m_dir;
    endcase
    resp_q.push_back('{r[0], m_rd[r]});
    m_last = r[0];
    cs0 = cs_cnt;
    @(posedge clk); #1;
    drive(r, 1'b1, op, mask, data);
    lat = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if ((r == 0) ? req0_done : req1_done) seen = 1;
      else lat++;
    end
    check("done_timeout", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    drive(r, 1'b0, 2'b00, '0, '0);
    check("latency", lat, exp_lat);
    check("cs_count", cs_cnt - cs0, exp_cs);
    check("out_shadow", out_shadow, m_out);
    check("dir_shadow", dir_shadow, m_dir);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fc0, fc1;
    logic s;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", {31'd0, pio_chipselect}, 0);
    check("rst_write_n", {31'd0, pio_write_n}, 1);
    check("rst_addr", {30'd0, pio_address}, 0);
    check("rst_wdata", pio_writedata, 0);
    check("rst_shadows", out_shadow | dir_shadow, 0);
    check("rst_rdata", req0_rdata | req1_rdata, 0);
    check("rst_done", {30'd0, req0_done, req1_done}, 0);
    reset_n = 1'b1;

    // Masked data_out writes build on the shadow.
    do_req(0, 2'b01, 32'h0000_00FF, 32'hA5A5_A5A5, 2, 1);
    check("t1_shadow", out_shadow, 32'h0000_00A5);
    do_req(0, 2'b01, 32'h0000_FF00, 32'h1234_5678, 2, 1);
    check("t2_shadow", out_shadow, 32'h0000_56A5);
    // Direction write then shadow read with no bus access.
    do_req(1, 2'b10, 32'hFFFF_FFFF, 32'h0000_000F, 2, 1);
    do_req(1, 2'b11, 32'h0, 32'h0, 2, 0);
    check("t3_rdata", req1_rdata, 32'h0000_000F);
    // mask=0 still writes the unchanged shadow.
    do_req(1, 2'b01, 32'h0, 32'hFFFF_FFFF, 2, 1);
    // Pin read.
    pins = 32'hDEAD_BEEF;
    do_req(0, 2'b00, 32'h0, 32'h0, 3, 1);
    check("t4_rdata", req0_rdata, 32'hDEAD_BEEF);
    check("t4_rdata1_kept", req1_rdata, 32'h0000_000F);

    // Both requesters held valid: round-robin alternates, fixed priority serves only req0.
    s = ~m_last;
    for (int i = 0; i < 4; i++) begin
      resp_q.push_back('{s, m_dir});
      m_rd[s] = m_dir;
      m_last = s;
      s = ~s;
    end
    fc0 = f0_cnt;
    fc1 = f1_cnt;
    @(posedge clk); #1;
    drive(0, 1'b1, 2'b11, '0, '0);
    drive(1, 1'b1, 2'b11, '0, '0);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (req0_done || req1_done) n++;
    end
    check("rr_count", n, 4);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, '0, '0);
    drive(1, 1'b0, 2'b00, '0, '0);
    check("fix_req0_served", f0_cnt - fc0, 4);
    check("fix_req1_starved", f1_cnt - fc1, 0);
    check("fix_rdata0", f_rdata0, 32'h0000_000F);

    // Reset during EXEC of a data_out write abandons it.
    @(posedge clk); #1;
    drive(0, 1'b1, 2'b01, 32'h0000_00FF, 32'h0000_0077);
    @(posedge clk); #1;
    check("exec_write_seen", {31'd0, pio_write_n}, 0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_write_n", {31'd0, pio_write_n}, 1);
    check("rst_mid_cs", {31'd0, pio_chipselect}, 0);
    check("rst_mid_shadows", out_shadow | dir_shadow, 0);
    drive(0, 1'b0, 2'b00, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", {30'd0, req0_done, req1_done}, 0);
    end
    m_out = '0;
    m_dir = '0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    m_last = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_req(0, 2'b01, 32'h0000_00FF, 32'h0000_003C, 2, 1);
    check("t6_shadow", out_shadow, 32'h0000_003C);

    repeat (3) @(posedge clk);
    check("resp_q_empty", resp_q.size(), 0);
    check("bus_q_empty", bus_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
